// File: rtl/wb_burst_reader_if.sv
// -----------------------------------------------------------------------------
// wb_burst_reader_if
// Wishbone B4 registered-feedback master bus used by wb_burst_reader.
//   master modport : drives adr/bte/cti/cyc/stb/we/sel/dat_o, samples ack/err/dat_i
//   slave  modport : the mirror image, for a slave model or a real slave
// Signal names keep the wbm_*_o / wbm_*_i names as seen from the master.
// -----------------------------------------------------------------------------
interface wb_burst_reader_if;
  logic [31:0] wbm_adr_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
           wbm_we_o, wbm_sel_o, wbm_dat_o,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o, wbm_bte_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
           wbm_we_o, wbm_sel_o, wbm_dat_o,
    output wbm_ack_i, wbm_err_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_burst_reader.sv
// -----------------------------------------------------------------------------
// wb_burst_reader
// Reads a block of 32-bit words over Wishbone using incrementing linear bursts
// (cti 010 ... 111) and queues the data in a first-word-fall-through FIFO.
// A burst is only launched when the FIFO has room for the whole burst, so the
// FIFO can never overflow and the bus never has to be stalled by the master.
//
// Ports
//   wb_clk, wb_rst  : clock, synchronous active-high reset
//   start_i         : one-cycle request, ignored while busy_o=1
//   base_adr_i      : byte address of first word ([1:0] ignored)
//   word_cnt_i      : number of words to read (0 = immediate completion)
//   busy_o/done_o   : transfer in progress / one-cycle completion pulse
//   err_o           : sticky bus error, cleared by the next accepted start
//   wbm             : Wishbone master bus (wb_burst_reader_if.master)
//   data_o/valid_o  : FIFO head word / FIFO not empty
//   ready_i         : consumer takes data_o when valid_o && ready_i
// Parameters
//   BURST_LEN  : max beats per burst, power of 2 in 1..16
//   FIFO_DEPTH : FIFO entries, power of 2, >= BURST_LEN and >= 2
// -----------------------------------------------------------------------------
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  start_i,
  input  logic [31:0]           base_adr_i,
  input  logic [15:0]           word_cnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  wb_burst_reader_if.master     wbm,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    FINISH
  } state_t;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [31:0] adr_reg;
  logic [2:0]  cti_reg;
  logic        cyc_reg;
  logic [15:0] remaining_reg;
  logic [4:0]  beats_reg;      // beats still to be acked in the current burst
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;

  // ---------------------------------------------------------------------------
  // FIFO registers
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      head_reg;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] free_cnt;
  logic [4:0]       burst_len;
  logic             space_ok;

  // The two address LSBs are don't-care; fold them into a sink.
  logic unused_bits;
  assign unused_bits = ^base_adr_i[1:0];

  // Length of the next burst: min(BURST_LEN, remaining). When remaining is
  // below BURST_LEN (<= 16) it fits in 5 bits.
  assign burst_len = (remaining_reg >= 16'(BURST_LEN)) ? 5'(BURST_LEN)
                                                       : remaining_reg[4:0];
  assign free_cnt  = DEPTH_C - count_reg;
  assign space_ok  = 32'(free_cnt) >= 32'(burst_len);

  // An error on a beat discards that beat's data.
  assign push = (state_reg == BURST) && wbm.wbm_ack_i && !wbm.wbm_err_i;
  assign pop  = valid_o && ready_i;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg     <= IDLE;
      adr_reg       <= 32'h0;
      cti_reg       <= CTI_CLASSIC;
      cyc_reg       <= 1'b0;
      remaining_reg <= 16'h0;
      beats_reg     <= 5'h0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            adr_reg       <= {base_adr_i[31:2], 2'b00};
            remaining_reg <= word_cnt_i;
            busy_reg      <= 1'b1;
            err_reg       <= 1'b0;
            state_reg     <= (word_cnt_i == 16'h0) ? FINISH : WAIT_SPACE;
          end
        end

        WAIT_SPACE: begin
          // Launch only when the whole burst fits; pops can only add room
          // while we wait, and nothing pushes outside BURST.
          if (space_ok) begin
            cyc_reg   <= 1'b1;
            beats_reg <= burst_len;
            cti_reg   <= (burst_len == 5'd1) ? CTI_END : CTI_INCR;
            state_reg <= BURST;
          end
        end

        BURST: begin
          if (wbm.wbm_err_i) begin
            cyc_reg   <= 1'b0;
            cti_reg   <= CTI_CLASSIC;
            err_reg   <= 1'b1;
            state_reg <= FINISH;
          end else if (wbm.wbm_ack_i) begin
            adr_reg       <= adr_reg + 32'd4;
            remaining_reg <= remaining_reg - 16'd1;
            beats_reg     <= beats_reg - 5'd1;
            if (beats_reg == 5'd1) begin
              cyc_reg   <= 1'b0;
              cti_reg   <= CTI_CLASSIC;
              state_reg <= (remaining_reg == 16'd1) ? FINISH : WAIT_SPACE;
            end else if (beats_reg == 5'd2) begin
              // The beat presented next is the last one of this burst.
              cti_reg <= CTI_END;
            end
          end
        end

        FINISH: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: write port plus a registered read feeding the head register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wbm.wbm_dat_i;
    end
  end

  assign rd_ptr_next = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= 32'h0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Head refresh: when the word being written lands exactly at the new
      // head position (empty FIFO, or last word popped while pushing), the
      // array still holds stale data, so bypass the incoming word.
      if (push || pop) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
          head_reg <= wbm.wbm_dat_i;
        end else begin
          head_reg <= mem[rd_ptr_next];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign err_o   = err_reg;
  assign data_o  = head_reg;
  assign valid_o = (count_reg != '0);

  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_bte_o = 2'b00;
  assign wbm.wbm_cti_o = cti_reg;
  assign wbm.wbm_cyc_o = cyc_reg;
  assign wbm.wbm_stb_o = cyc_reg;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'hF;
  assign wbm.wbm_dat_o = 32'h0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_reader
// Scoreboard bench for wb_burst_reader (BURST_LEN=8, FIFO_DEPTH=16).
// Stimulus pushes the expected bus beats (address, cti, burst start) and the
// expected output words into queues; a bus monitor / zero-wait slave and a
// data monitor pop and compare on every beat and every FIFO pop.
// Inputs change at posedge+1; monitors sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_burst_reader;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        start_i;
  logic [31:0] base_adr_i;
  logic [15:0] word_cnt_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  wb_burst_reader_if wb_bus();

  wb_burst_reader #(
    .BURST_LEN (8),
    .FIFO_DEPTH(16)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .start_i   (start_i),
    .base_adr_i(base_adr_i),
    .word_cnt_i(word_cnt_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .wbm       (wb_bus),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    bit          first;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_words[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int beats_seen = 0;
  int err_beat = 0;   // 1-based beat within a burst that the slave errors, 0 = none

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Expected model: bursts of min(8, remaining), cti 010 except the last beat
  // (111). With err_beat set, the transfer stops at that beat of the first
  // burst and that beat's data is not expected.
  task automatic expect_xfer(input logic [31:0] base, input int cnt, input int eb);
    int    pos;
    int    first_i;
    int    l;
    beat_t b;
    for (int i = 0; i < cnt; i++) begin
      pos     = i % 8;
      first_i = i - pos;
      l       = (cnt - first_i < 8) ? (cnt - first_i) : 8;
      b.adr   = base + 32'(4 * i);
      b.cti   = (pos == l - 1) ? 3'b111 : 3'b010;
      b.first = (pos == 0);
      exp_beats.push_back(b);
      if (eb != 0 && i == eb - 1) break;
      exp_words.push_back(data_of(b.adr));
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
    @(posedge wb_clk); #1;
    start_i    = 1'b1;
    base_adr_i = base;
    word_cnt_i = cnt;
    @(posedge wb_clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n    = 0;
    bit seen = 1'b0;
    while (n < budget && !seen) begin
      @(posedge wb_clk); #1;
      n++;
      if (done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
      @(posedge wb_clk); #1;
      check({tag, "_done_width"}, 32'(done_o), 32'd0);
    end
    $display("xfer %s: done after %0d cycles, err_o=%0b", tag, n, err_o);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (n < budget && (exp_words.size() != 0 || valid_o)) begin
      @(posedge wb_clk); #1;
      n++;
    end
    check({tag, "_words_left"}, 32'(exp_words.size()), 32'd0);
    check({tag, "_fifo_empty"}, 32'(valid_o), 32'd0);
  endtask

  // Bus monitor and zero-wait slave
  initial begin
    beat_t b;
    int    idx;
    bit    prev_cyc;
    idx      = 0;
    prev_cyc = 1'b0;
    wb_bus.wbm_ack_i = 1'b0;
    wb_bus.wbm_err_i = 1'b0;
    wb_bus.wbm_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk);
      if (wb_bus.wbm_cyc_o && wb_bus.wbm_stb_o) begin
        beats_seen++;
        idx++;
        if (exp_beats.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: adr 0x%08h on bus, expected no beat", wb_bus.wbm_adr_o);
        end else begin
          b = exp_beats.pop_front();
          check("beat_adr", wb_bus.wbm_adr_o, b.adr);
          check("beat_cti", 32'(wb_bus.wbm_cti_o), 32'(b.cti));
          check("beat_burst_edge", 32'(prev_cyc), 32'(!b.first));
          check("beat_static", {wb_bus.wbm_bte_o, wb_bus.wbm_we_o, wb_bus.wbm_sel_o, wb_bus.wbm_dat_o[24:0]},
                {2'b00, 1'b0, 4'hF, 25'h0});
        end
        if (err_beat != 0 && idx == err_beat) begin
          wb_bus.wbm_ack_i = 1'b0;
          wb_bus.wbm_err_i = 1'b1;
        end else begin
          wb_bus.wbm_ack_i = 1'b1;
          wb_bus.wbm_err_i = 1'b0;
        end
        wb_bus.wbm_dat_i = data_of(wb_bus.wbm_adr_o);
      end else begin
        idx = 0;
        wb_bus.wbm_ack_i = 1'b0;
        wb_bus.wbm_err_i = 1'b0;
      end
      prev_cyc = wb_bus.wbm_cyc_o;
    end
  end

  // Data monitor
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst && valid_o && ready_i) begin
        if (exp_words.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_word: data_o 0x%08h popped, expected none", data_o);
        end else begin
          w = exp_words.pop_front();
          check("rd_data", data_o, w);
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    int n;
    wb_rst     = 1'b1;
    start_i    = 1'b0;
    base_adr_i = 32'h0;
    word_cnt_i = 16'h0;
    ready_i    = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    check("rst_cyc",   32'(wb_bus.wbm_cyc_o), 32'd0);
    check("rst_stb",   32'(wb_bus.wbm_stb_o), 32'd0);
    check("rst_adr",   wb_bus.wbm_adr_o, 32'h0);
    check("rst_cti",   32'(wb_bus.wbm_cti_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data",  data_o, 32'h0);
    wb_rst = 1'b0;

    // Single full burst
    expect_xfer(32'h100, 8, 0);
    do_start(32'h100, 16'd8);
    check("s1_busy", 32'(busy_o), 32'd1);
    wait_done(60, "s1");
    drain(60, "s1");

    // 20 words: bursts of 8, 8, 4
    expect_xfer(32'h100, 20, 0);
    do_start(32'h100, 16'd20);
    wait_done(120, "s2");
    drain(60, "s2");

    // 32 words with the consumer stalled: two bursts then WAIT_SPACE
    ready_i = 1'b0;
    expect_xfer(32'h1000, 32, 0);
    do_start(32'h1000, 16'd32);
    repeat (60) @(posedge wb_clk);
    #1;
    check("s3_beats_pending", 32'(exp_beats.size()), 32'd16);
    check("s3_busy", 32'(busy_o), 32'd1);
    check("s3_cyc_stalled", 32'(wb_bus.wbm_cyc_o), 32'd0);
    check("s3_valid", 32'(valid_o), 32'd1);
    do_start(32'h9000, 16'd4);   // must be ignored while busy
    ready_i = 1'b1;
    wait_done(300, "s3");
    drain(60, "s3");

    // Bus error on beat 3 of 8
    ready_i  = 1'b0;
    err_beat = 3;
    expect_xfer(32'h2000, 8, 3);
    do_start(32'h2000, 16'd8);
    wait_done(60, "s4");
    check("s4_err", 32'(err_o), 32'd1);
    check("s4_valid", 32'(valid_o), 32'd1);
    err_beat = 0;
    ready_i  = 1'b1;
    drain(40, "s4");
    expect_xfer(32'h3000, 1, 0);
    do_start(32'h3000, 16'd1);
    check("s4_err_cleared", 32'(err_o), 32'd0);
    wait_done(40, "s4b");
    drain(40, "s4b");

    // Zero-length request: done two cycles after start, no bus cycle
    do_start(32'h500, 16'd0);
    check("s5_busy", 32'(busy_o), 32'd1);
    @(posedge wb_clk); #1;
    check("s5_done", 32'(done_o), 32'd1);
    check("s5_busy_clr", 32'(busy_o), 32'd0);
    @(posedge wb_clk); #1;
    check("s5_done_width", 32'(done_o), 32'd0);
    $display("xfer s5: zero-length request completed");

    // Reset in the middle of a burst
    ready_i = 1'b0;
    expect_xfer(32'h4000, 16, 0);
    seen0 = beats_seen;
    do_start(32'h4000, 16'd16);
    n = 0;
    while (n < 40 && beats_seen < seen0 + 3) begin
      @(posedge wb_clk); #1;
      n++;
    end
    check("s6_beats_before_rst", 32'(beats_seen >= seen0 + 3), 32'd1);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    check("s6_cyc",   32'(wb_bus.wbm_cyc_o), 32'd0);
    check("s6_valid", 32'(valid_o), 32'd0);
    check("s6_busy",  32'(busy_o), 32'd0);
    check("s6_adr",   wb_bus.wbm_adr_o, 32'h0);
    check("s6_data",  data_o, 32'h0);
    exp_beats.delete();
    exp_words.delete();
    wb_rst  = 1'b0;
    ready_i = 1'b1;
    $display("xfer s6: reset applied mid-burst");
    expect_xfer(32'h5000, 4, 0);
    do_start(32'h5000, 16'd4);
    wait_done(40, "s6b");
    drain(40, "s6b");

    repeat (5) @(posedge wb_clk);
    #1;
    check("end_beats_left", 32'(exp_beats.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, meaning maximum beats per Wishbone burst (power of 2, 1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the output FIFO depth (power of 2, >= BURST_LEN).
REQ-003 SHALL use one clock and a synchronous, active-high reset, as decided.
- wb_clk  in  1  sole clock; all logic on the rising edge.
- wb_rst  in  1  synchronous active-high reset.
REQ-004 SHALL provide these ports:
- start_i  in  1  one-cycle request to start a block read.
- base_adr_i  in  32  byte address of the first word; bits [1:0] ignored.
- word_cnt_i  in  16  number of 32-bit words to read.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky bus error flag.
- wbm_adr_o  out  32  Wishbone address.
- wbm_bte_o  out  2  burst type extension, always 2'b00 (linear).
- wbm_cti_o  out  3  cycle type identifier.
- wbm_cyc_o, wbm_stb_o  out  1  each  bus cycle and strobe.
- wbm_we_o  out  1  always 0.
- wbm_sel_o  out  4  always 4'hF.
- wbm_dat_o  out  32  always 0.
- wbm_ack_i, wbm_err_i  in  1  each  slave acknowledge and error.
- wbm_dat_i  in  32  read data.
- data_o  out  32  FIFO head word.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o.

Function
REQ-005 SHALL implement states IDLE, WAIT_SPACE, BURST and FINISH.
REQ-006 SHALL, in IDLE when start_i=1, latch base_adr_i[31:2] and word_cnt_i, assert busy_o, and go to WAIT_SPACE; if word_cnt_i=0 it SHALL go to FINISH instead.
REQ-007 SHALL ignore start_i whenever busy_o=1.
REQ-008 SHALL define burst length L = min(BURST_LEN, remaining words).
REQ-009 SHALL, in WAIT_SPACE, stay until FIFO free entries >= L, then assert cyc/stb on the next cycle and enter BURST.
REQ-010 SHALL drive cti=3'b010 on every beat of a burst except the last, and cti=3'b111 on the last beat; L=1 SHALL use 3'b111 only.
REQ-011 SHALL, on each ack in BURST, push wbm_dat_i into the FIFO, add 4 to wbm_adr_o and decrement remaining; cyc/stb stay high across beats with no idle cycles inserted by the master.
REQ-012 SHALL, on the ack of the last beat, deassert cyc/stb on the next cycle; it SHALL go to WAIT_SPACE if remaining>0, else to FINISH.
REQ-013 SHALL, on wbm_err_i during BURST, deassert cyc/stb the next cycle, discard that beat, set err_o, and go to FINISH; remaining words are abandoned.
REQ-014 SHALL, in FINISH, pulse done_o for exactly one cycle, clear busy_o, and return to IDLE; the FIFO is not flushed.
REQ-015 SHALL clear err_o when a new start_i is accepted.
REQ-016 SHALL pop the FIFO when valid_o&&ready_i; a simultaneous push and pop SHALL leave the count unchanged, including at full or empty.
REQ-017 SHALL present data_o as the registered head word, with first-word fall-through; valid_o SHALL assert the cycle after the first push.
REQ-018 SHALL never overflow the FIFO; the space check in REQ-009 guarantees this.
REQ-019 SHALL let the address increment wrap modulo 2^32.

Reset
REQ-020 SHALL, on wb_rst=1, apply the following at the next edge, including mid-burst:
- state=IDLE;
- cyc/stb/busy_o/done_o/err_o=0;
- wbm_adr_o=0, wbm_cti_o=0;
- FIFO empty (valid_o=0), data_o=0.

Verification
REQ-021 SHALL cover these directed scenarios:
- base=0x100, cnt=8, ready_i=1 -> one burst at adr 0x100..0x11C, cti 010x7 then 111; 8 words out in order; done_o 1 cycle.
- cnt=20, BURST_LEN=8 -> bursts of 8, 8, 4; cyc drops between bursts; final adr 0x14C.
- cnt=32, ready_i=0 -> two bursts (16 words), then WAIT_SPACE stall; raising ready_i resumes reading and all 32 words are delivered.
- wbm_err_i on beat 3 of 8 -> cyc low next cycle; 2 words in FIFO; err_o=1; done_o pulse; next start clears err_o.
- cnt=0 -> no bus cycle; done_o pulses 2 cycles after start.
- wb_rst mid-burst -> cyc=0 and valid_o=0 next cycle; a new start restarts cleanly.
